// File: rtl/enc_speed_sched.sv
// enc_speed_sched: measurement-window scheduler turning two encoder counts into PWM duty words via one shared divider
module enc_speed_sched #(
    parameter int CLK_PER_MS  = 4000,
    parameter int CNT_W       = 16,
    parameter int DUTY_W      = 10,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              R,
    input  logic [3:0]              PR,
    input  logic [CNT_W-1:0]        cnt_ab,
    input  logic [CNT_W-1:0]        cnt_cd,
    input  logic                    ovr_clr,
    output logic                    cnt_clr,
    output logic                    div_start,
    output logic [CNT_W+DUTY_W-1:0] div_num,
    output logic [15:0]             div_den,
    input  logic                    div_done,
    input  logic [CNT_W+DUTY_W-1:0] div_quo,
    output logic [DUTY_W-1:0]       duty_ab,
    output logic [DUTY_W-1:0]       duty_cd,
    output logic                    dir_ab,
    output logic                    dir_cd,
    output logic                    duty_vld,
    output logic                    overrun,
    output logic                    div_err
);
    localparam int WIN_W = $clog2(CLK_PER_MS * 128);
    localparam int TMR_W = $clog2(DIV_TIMEOUT + 1);
    localparam int NUM_W = CNT_W + DUTY_W;

    typedef enum logic [2:0] {IDLE, REQ_AB, WAIT_AB, REQ_CD, WAIT_CD, UPDATE} state_t;
    state_t state, state_nx;

    logic [WIN_W-1:0]  win_cnt, win_last;
    logic [2:0]        r_lat;
    logic [3:0]        pr_lat;
    logic              first;
    logic [CNT_W-1:0]  snap_ab, snap_cd;
    logic [DUTY_W-1:0] pend_ab, pend_cd, duty_sat;
    logic [TMR_W-1:0]  tmr;
    logic              tick, busy, waiting, timeout, sel_ab, sel_cd;

    // |c| with the most negative code clamped so it never wraps back to negative
    function automatic logic [CNT_W-1:0] sat_abs(input logic [CNT_W-1:0] c);
        return c[CNT_W-1] ? (c == {1'b1, {(CNT_W-1){1'b0}}} ? {1'b0, {(CNT_W-1){1'b1}}} : -c) : c;
    endfunction

    assign win_last  = (WIN_W'(CLK_PER_MS) << r_lat) - WIN_W'(1);
    assign tick      = win_cnt == win_last;
    assign busy      = state != IDLE;
    assign sel_ab    = state == REQ_AB || state == WAIT_AB;
    assign sel_cd    = state == REQ_CD || state == WAIT_CD;
    assign waiting   = state == WAIT_AB || state == WAIT_CD;
    assign timeout   = waiting && !div_done && tmr == TMR_W'(DIV_TIMEOUT - 1);
    assign div_start = state == REQ_AB || state == REQ_CD;
    assign div_num   = sel_ab ? {sat_abs(snap_ab), {DUTY_W{1'b0}}} :
                       sel_cd ? {sat_abs(snap_cd), {DUTY_W{1'b0}}} : '0;
    assign div_den   = (sel_ab || sel_cd) ? {3'b0, 5'({1'b0, pr_lat}) + 5'd1, 8'b0} : '0;
    assign duty_sat  = |div_quo[NUM_W-1:DUTY_W] ? '1 : div_quo[DUTY_W-1:0];

    // sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // sequencer next state: AB division, then CD division, then publish; abort on timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = tick ? REQ_AB : IDLE;
            REQ_AB:  state_nx = WAIT_AB;
            WAIT_AB: state_nx = div_done ? REQ_CD : timeout ? IDLE : WAIT_AB;
            REQ_CD:  state_nx = WAIT_CD;
            WAIT_CD: state_nx = div_done ? UPDATE : timeout ? IDLE : WAIT_CD;
            default: state_nx = IDLE;
        endcase
    end

    // window counter; R/PR captured on the first cycle out of reset and at every tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
            r_lat   <= '0;
            pr_lat  <= '0;
            first   <= 1'b1;
        end else begin
            win_cnt <= tick ? '0 : win_cnt + WIN_W'(1);
            first   <= 1'b0;
            if (tick || first) begin
                r_lat  <= R;
                pr_lat <= PR;
            end
        end
    end

    // count snapshot, decoder clear pulse and sticky fault flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_ab <= '0;
            snap_cd <= '0;
            cnt_clr <= 1'b0;
            overrun <= 1'b0;
            div_err <= 1'b0;
        end else begin
            cnt_clr <= tick && !busy;
            if (tick && !busy) begin
                snap_ab <= cnt_ab;
                snap_cd <= cnt_cd;
            end
            overrun <= !ovr_clr && (overrun || (tick && busy));
            div_err <= !ovr_clr && (div_err || timeout);
        end
    end

    // divider wait timer and saturated results awaiting publication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr     <= '0;
            pend_ab <= '0;
            pend_cd <= '0;
        end else begin
            tmr <= waiting ? tmr + TMR_W'(1) : TMR_W'(1);
            if (state == WAIT_AB && div_done) pend_ab <= duty_sat;
            if (state == WAIT_CD && div_done) pend_cd <= duty_sat;
        end
    end

    // both channels' duty and direction change together with a single valid pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_ab  <= '0;
            duty_cd  <= '0;
            dir_ab   <= 1'b0;
            dir_cd   <= 1'b0;
            duty_vld <= 1'b0;
        end else begin
            duty_vld <= state == UPDATE;
            if (state == UPDATE) begin
                duty_ab <= pend_ab;
                duty_cd <= pend_cd;
                dir_ab  <= snap_ab[CNT_W-1];
                dir_cd  <= snap_cd[CNT_W-1];
            end
        end
    end
endmodule

// File: tb/tb_enc_speed_sched.sv
// tb_enc_speed_sched: directed bench for the window scheduler, with a short-window instance for overrun cases
module tb_enc_speed_sched;
    localparam int S_CLR = 0, S_START = 1, S_VLD = 2, S_ERR = 3, S_FOVR = 4, S_FSTART = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  R;
    logic [3:0]  PR;
    logic [15:0] cnt_ab, cnt_cd;
    logic        ovr_clr, cnt_clr, div_start, div_done;
    logic [25:0] div_num, div_quo;
    logic [15:0] div_den;
    logic [9:0]  duty_ab, duty_cd;
    logic        dir_ab, dir_cd, duty_vld, overrun, div_err;

    logic [15:0] f_cnt_ab;
    logic        f_ovr_clr, f_cnt_clr, f_div_start, f_div_done;
    logic [25:0] f_div_num, f_div_quo;
    logic [15:0] f_div_den;
    logic [9:0]  f_duty_ab, f_duty_cd;
    logic        f_dir_ab, f_dir_cd, f_duty_vld, f_overrun, f_div_err;

    int checks = 0;
    int errors = 0;
    int div_lat = 20;
    bit div_on = 1'b1;

    always #5 clk = ~clk;

    enc_speed_sched dut (
        .clk(clk), .reset(reset), .R(R), .PR(PR), .cnt_ab(cnt_ab), .cnt_cd(cnt_cd),
        .ovr_clr(ovr_clr), .cnt_clr(cnt_clr), .div_start(div_start), .div_num(div_num),
        .div_den(div_den), .div_done(div_done), .div_quo(div_quo), .duty_ab(duty_ab),
        .duty_cd(duty_cd), .dir_ab(dir_ab), .dir_cd(dir_cd), .duty_vld(duty_vld),
        .overrun(overrun), .div_err(div_err)
    );

    enc_speed_sched #(.CLK_PER_MS(50)) fast (
        .clk(clk), .reset(reset), .R(3'd1), .PR(4'd0), .cnt_ab(f_cnt_ab), .cnt_cd(16'd0),
        .ovr_clr(f_ovr_clr), .cnt_clr(f_cnt_clr), .div_start(f_div_start), .div_num(f_div_num),
        .div_den(f_div_den), .div_done(f_div_done), .div_quo(f_div_quo), .duty_ab(f_duty_ab),
        .duty_cd(f_duty_cd), .dir_ab(f_dir_ab), .dir_cd(f_dir_cd), .duty_vld(f_duty_vld),
        .overrun(f_overrun), .div_err(f_div_err)
    );

    // divider models (main: programmable latency, can withhold done; fast: latency 60)
    // and a decoder model for the fast instance that counts one edge per clock
    initial begin
        int pend = 0, f_pend = 0;
        logic [25:0] qn = '0, fqn = '0;
        logic [15:0] qd = 16'd1, fqd = 16'd1;
        div_done = 1'b0; div_quo = '0; f_div_done = 1'b0; f_div_quo = '0; f_cnt_ab = '0;
        forever begin
            @(posedge clk);
            #1;
            div_done = 1'b0;
            f_div_done = 1'b0;
            f_cnt_ab = (reset || f_cnt_clr) ? 16'd0 : f_cnt_ab + 16'd1;
            if (reset) begin
                pend = 0;
                f_pend = 0;
            end else begin
                if (pend == 0) begin
                    if (div_start && div_on) begin pend = div_lat; qn = div_num; qd = div_den; end
                end else begin
                    pend--;
                    if (pend == 0) begin div_done = 1'b1; div_quo = qn / 26'(qd); end
                end
                if (f_pend == 0) begin
                    if (f_div_start) begin f_pend = 60; fqn = f_div_num; fqd = f_div_den; end
                end else begin
                    f_pend--;
                    if (f_pend == 0) begin f_div_done = 1'b1; f_div_quo = fqn / 26'(fqd); end
                end
            end
        end
    end

    function automatic logic sig(input int s);
        return s == S_CLR ? cnt_clr : s == S_START ? div_start : s == S_VLD ? duty_vld :
               s == S_ERR ? div_err : s == S_FOVR ? f_overrun : f_div_start;
    endfunction

    task automatic wait_hi(input int s, input int lim, input string name, output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!sig(s) && n < lim);
        checks++;
        if (!sig(s)) begin errors++; $display("FAIL %s: no pulse within %0d cycles", name, n); end
    endtask

    task automatic test_reset();
        int n;
        R = 3'd0; PR = 4'd0; cnt_ab = '0; cnt_cd = '0; ovr_clr = 1'b0; f_ovr_clr = 1'b0;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({cnt_clr, div_start, duty_vld, overrun, div_err, dir_ab, dir_cd} !== 7'd0 ||
            duty_ab !== 10'd0 || duty_cd !== 10'd0 || div_num !== 26'd0 || div_den !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: clr=%b start=%b vld=%b ovr=%b err=%b duty_ab=%0d duty_cd=%0d num=%0d den=%0d, all required 0",
                     cnt_clr, div_start, duty_vld, overrun, div_err, duty_ab, duty_cd, div_num, div_den);
        end
        reset = 1'b0;
        wait_hi(S_CLR, 5000, "first_cnt_clr", n);
        checks++;
        if (n !== 4000) begin errors++; $display("FAIL first_cnt_clr: after %0d clocks, required 4000", n); end
        @(posedge clk); #1;
        checks++;
        if (cnt_clr !== 1'b0) begin errors++; $display("FAIL cnt_clr_width: got %b required 0", cnt_clr); end
        wait_hi(S_CLR, 5000, "second_cnt_clr", n);
        checks++;
        if (n + 1 !== 4000) begin errors++; $display("FAIL second_cnt_clr: period %0d required 4000", n + 1); end
    endtask

    task automatic test_duty();
        int n;
        wait_hi(S_VLD, 200, "zero_vld", n);
        checks++;
        if (duty_ab !== 10'd0 || duty_cd !== 10'd0) begin
            errors++; $display("FAIL zero_count_duty: ab=%0d cd=%0d required 0 0", duty_ab, duty_cd);
        end
        PR = 4'd15; cnt_ab = 16'd2048; cnt_cd = 16'hE000;
        wait_hi(S_START, 4100, "ab_start", n);
        checks++;
        if (div_num !== 26'd2097152 || div_den !== 16'd4096) begin
            errors++; $display("FAIL ab_operands: num=%0d den=%0d required 2097152 4096", div_num, div_den);
        end
        wait_hi(S_START, 100, "cd_start", n);
        checks++;
        if (div_num !== 26'd8388608 || div_den !== 16'd4096) begin
            errors++; $display("FAIL cd_operands: num=%0d den=%0d required 8388608 4096", div_num, div_den);
        end
        wait_hi(S_VLD, 100, "duty_vld", n);
        checks++;
        if (duty_ab !== 10'd512 || dir_ab !== 1'b0) begin
            errors++; $display("FAIL duty_ab: duty=%0d dir=%b required 512 0", duty_ab, dir_ab);
        end
        checks++;
        if (duty_cd !== 10'd1023 || dir_cd !== 1'b1) begin
            errors++; $display("FAIL duty_cd_sat: duty=%0d dir=%b required 1023 1", duty_cd, dir_cd);
        end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL no_overrun: got %b required 0", overrun); end
        @(posedge clk); #1;
        checks++;
        if (duty_vld !== 1'b0) begin errors++; $display("FAIL vld_width: got %b required 0", duty_vld); end
    endtask

    task automatic test_min_neg();
        int n;
        cnt_ab = 16'h8000; cnt_cd = 16'd0;
        wait_hi(S_START, 4100, "minneg_start", n);
        checks++;
        if (div_num !== 26'd33553408) begin
            errors++; $display("FAIL minneg_operand: num=%0d required 33553408", div_num);
        end
        wait_hi(S_VLD, 100, "minneg_vld", n);
        checks++;
        if (duty_ab !== 10'd1023 || dir_ab !== 1'b1 || duty_cd !== 10'd0 || dir_cd !== 1'b0) begin
            errors++; $display("FAIL minneg_duty: ab=%0d/%b cd=%0d/%b required 1023/1 0/0", duty_ab, dir_ab, duty_cd, dir_cd);
        end
    endtask

    task automatic test_timeout();
        int n;
        div_on = 1'b0;
        wait_hi(S_START, 4100, "timeout_start", n);
        wait_hi(S_ERR, 100, "div_err", n);
        checks++;
        if (n !== 64) begin errors++; $display("FAIL timeout_latency: div_err after %0d clocks, required 64", n); end
        checks++;
        if (duty_ab !== 10'd1023 || dir_ab !== 1'b1 || duty_cd !== 10'd0 || dir_cd !== 1'b0 || duty_vld !== 1'b0) begin
            errors++; $display("FAIL duties_kept: ab=%0d/%b cd=%0d/%b vld=%b required 1023/1 0/0 0", duty_ab, dir_ab, duty_cd, dir_cd, duty_vld);
        end
        div_on = 1'b1; cnt_ab = 16'd512; cnt_cd = 16'hFC18;
        wait_hi(S_VLD, 4200, "recover_vld", n);
        checks++;
        if (duty_ab !== 10'd128 || dir_ab !== 1'b0 || duty_cd !== 10'd250 || dir_cd !== 1'b1) begin
            errors++; $display("FAIL recover_duty: ab=%0d/%b cd=%0d/%b required 128/0 250/1", duty_ab, dir_ab, duty_cd, dir_cd);
        end
        checks++;
        if (div_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", div_err); end
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        checks++;
        if (div_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", div_err); end
    endtask

    task automatic test_overrun();
        int n;
        logic seen;
        seen = 1'b0;
        f_ovr_clr = 1'b1;
        repeat (250) begin @(posedge clk); #1; seen = seen | f_overrun; end
        f_ovr_clr = 1'b0;
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL ovr_clr_priority: overrun seen %b required 0", seen); end
        wait_hi(S_FOVR, 300, "overrun_set", n);
        checks++;
        if (f_cnt_clr !== 1'b0) begin errors++; $display("FAIL no_clr_at_busy_tick: cnt_clr=%b required 0", f_cnt_clr); end
        wait_hi(S_FSTART, 200, "overrun_next_start", n);
        checks++;
        if (f_div_num !== 26'd203776) begin
            errors++; $display("FAIL double_window_count: num=%0d required 203776", f_div_num);
        end
    endtask

    task automatic test_window_r();
        int n;
        wait_hi(S_CLR, 4100, "win_sync", n);
        repeat (1000) @(posedge clk);
        #1;
        R = 3'd2;
        wait_hi(S_CLR, 3100, "win_cur", n);
        checks++;
        if (n + 1000 !== 4000) begin errors++; $display("FAIL window_current: period %0d required 4000", n + 1000); end
        wait_hi(S_CLR, 16100, "win_next", n);
        checks++;
        if (n !== 16000) begin errors++; $display("FAIL window_next: period %0d required 16000", n); end
        R = 3'd0;
    endtask

    task automatic test_reset_mid();
        int n;
        wait_hi(S_START, 16100, "mid_start", n);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (div_start !== 1'b0 || duty_ab !== 10'd0 || duty_cd !== 10'd0 || dir_cd !== 1'b0 ||
            duty_vld !== 1'b0 || cnt_clr !== 1'b0) begin
            errors++; $display("FAIL async_reset_mid: start=%b ab=%0d cd=%0d dir_cd=%b vld=%b clr=%b required all 0",
                               div_start, duty_ab, duty_cd, dir_cd, duty_vld, cnt_clr);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_hi(S_CLR, 4100, "restart_clr", n);
        checks++;
        if (n !== 4000) begin errors++; $display("FAIL restart_cnt_clr: after %0d clocks, required 4000", n); end
        wait_hi(S_VLD, 100, "restart_vld", n);
        checks++;
        if (duty_ab !== 10'd128 || duty_cd !== 10'd250 || dir_cd !== 1'b1) begin
            errors++; $display("FAIL restart_duty: ab=%0d cd=%0d dir_cd=%b required 128 250 1", duty_ab, duty_cd, dir_cd);
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_min_neg();
        test_timeout();
        test_overrun();
        test_window_r();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
